alu_scheduler: RTL

- Shares the single 8-bit registered ALU (ADD/AND/OR/SUB/XOR/SLT/NOR, op codes 000–110) between NUM_REQ requesters.
- Round-robin arbitration over valid/ready request channels.
- Sequences one operation at a time through the ALU's one-cycle registered pipeline.
- Returns result and flags, tagged with requester id, on a single valid/ready response channel. Sits between issuing units and the ALU instance.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_scheduler_if.sv | 25 ++
 rtl/rr_arbiter.sv | 21 ++
 rtl/alu_scheduler.sv | 109 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, data width, scheduler FSM states and response flags
package alu_pkg;
    localparam int DATA_W = 8;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_NOR = 3'b110;
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} sched_state_t;
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              carry;
        logic              overflow;
    } rsp_flags_t;
endpackage

// File: rtl/alu_scheduler_if.sv
// alu_scheduler_if: packed request channels and the tagged response channel of the ALU scheduler
interface alu_scheduler_if #(parameter int NUM_REQ = 4);
    import alu_pkg::*;
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*3-1:0]      req_op;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_zero;
    logic                      rsp_carry;
    logic                      rsp_overflow;
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above the pointer, wrapping
module rr_arbiter #(parameter int N = 4, localparam int W = $clog2(N)) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any_grant
);
    // scan downward in distance so the closest request to the pointer wins
    always_comb begin
        idx = '0;
        any_grant = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = W'((int'(ptr) + k) % N);
                any_grant = 1'b1;
            end
        end
        grant = any_grant ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sharing of one registered ALU among NUM_REQ requesters
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_scheduler_if.slave    bus,
    output logic              busy,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_overflow
);
    localparam int ID_W = $clog2(NUM_REQ);

    sched_state_t      state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]        alu_op_q, alu_op_d;
    rsp_flags_t        rsp_q, rsp_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_idx;
    logic              any_grant;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .idx       (grant_idx),
        .any_grant (any_grant)
    );

    assign bus.req_ready    = (rst_n && state_q == IDLE) ? grant : '0;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_q.result;
    assign bus.rsp_zero     = rsp_q.zero;
    assign bus.rsp_carry    = rsp_q.carry;
    assign bus.rsp_overflow = rsp_q.overflow;
    assign busy   = state_q != IDLE;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

    // accept in IDLE, hold operands through EXEC, capture ALU output in CAPT, handshake in RESP
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_id_d    = rsp_id_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: if (any_grant) begin
                alu_a_d  = bus.req_a[int'(grant_idx) * DATA_W +: DATA_W];
                alu_b_d  = bus.req_b[int'(grant_idx) * DATA_W +: DATA_W];
                alu_op_d = bus.req_op[int'(grant_idx) * 3 +: 3];
                id_d     = grant_idx;
                ptr_d    = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                state_d  = EXEC;
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                rsp_d       = '{result: alu_result, zero: alu_result == '0, carry: alu_carry, overflow: alu_overflow};
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: if (bus.rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset aborts any in-flight op without a response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_id_q    <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
endmodule
